ahb_sram_bank_if: RTL and testbench
===================================

// Module: ahb_sram_bank_if
// PURPOSE
// - AHB-Lite slave front-end for the SRAM controller. Next generation of the AHB interface.
// - Decodes AHB transfers into per-bank, per-byte-lane SRAM strobes.
// - Parametrised in bank count, bank depth and data width. Zero-wait-state reads.
// - Writes retire one cycle late (data phase). Same-bank read-after-write collisions are stalled.
// PARAMETERS
// - ADDR_WIDTH       32  AHB address width
// - DATA_WIDTH       32  AHB/SRAM data width; multiple of 8; LANES = DATA_WIDTH/8
// - SRAM_ADDR_WIDTH  13  word address width of one bank
// - NUM_BANKS        2   SRAM banks; power of 2, >=1; BANK_BITS = $clog2(NUM_BANKS)
// PORTS
// - hclk         in   1                      AHB clock
// - hresetn      in   1                      async reset, active low
// - hsel         in   1                      slave select
// - haddr        in   ADDR_WIDTH             byte address
// - hwrite       in   1                      1=write
// - htrans       in   2                      IDLE/BUSY/NONSEQ/SEQ
// - hsize        in   3                      transfer size
// - hburst       in   3                      ignored; every beat is decoded independently
// - hready       in   1                      bus ready (previous data phase done)
// - hwdata       in   DATA_WIDTH             write data (data phase)
// - hready_resp  out  1                      slave ready
// - hresp        out  2                      00=OKAY, 01=ERROR
// - hrdata       out  DATA_WIDTH             read data
// - sram_cen     out  NUM_BANKS              per-bank chip enable, active low
// - sram_wen     out  LANES                  per-lane write enable, active low
// - sram_addr    out  SRAM_ADDR_WIDTH        word address (shared by all banks)
// - sram_wdata   out  DATA_WIDTH             write data
// - sram_rdata   in   NUM_BANKS*DATA_WIDTH   read data; bank b at [b*DATA_WIDTH +: DATA_WIDTH]; valid 1 cycle after cen
// BEHAVIOUR
// Interface: one clock; reset is asynchronous and active-low (hclk, hresetn).
// - Reset values: hready_resp=1, hresp=00, hrdata=0, sram_cen=all 1, sram_wen=all 1.
// - Reset mid-transfer discards a pending write; state returns to IDLE.
// Decode
// - Valid transfer = hsel & hready & htrans[1].
// - Word index = haddr[LSB +: SRAM_ADDR_WIDTH], where LSB = $clog2(LANES).
// - Bank = next BANK_BITS of haddr.
// - Lane mask = (2^hsize) lanes starting at haddr[LSB-1:0].
// Read (address cycle N)
// - sram_cen[bank]=0 and sram_addr are driven combinationally in N; sram_wen stays all 1.
// - In N+1: hrdata = bank slice selected by the registered bank; hready_resp=1.
// - hrdata=0 in any cycle that is not a read data phase.
// Write (address cycle N)
// - Address, bank and lane mask are registered in N.
// - In N+1: sram_cen[bank]=0, sram_wen = ~mask, sram_wdata = hwdata, hready_resp=1.
// Collision (state WR)
// - Condition: a read is presented to the same bank while a write data phase executes.
// - Cycle 1: hready_resp=0; the write completes.
// - Next cycle: the read issues; its data arrives one cycle later.
// - Read to a different bank during WR issues in parallel; no stall.
// - Write after write never stalls.
// State machine: IDLE, WR, ERR1, ERR2
// - Any -> WR on a valid legal write; WR -> IDLE when no new write.
// - ERRn states exist only with ERR_RESP_EN.
// - htrans IDLE/BUSY, or hsel=0: OKAY, zero wait, no SRAM access.
// CONFIGURATION
// Macro AHB_SRAM_ERR_RESP_EN.
// Defined
// - Illegal transfers get no SRAM access and a two-cycle ERROR:
//   ERR1: hresp=01, hready_resp=0; ERR2: hresp=01, hready_resp=1.
// - Illegal = hsize > LSB, misaligned address, or nonzero haddr bits above bank field.
// Undefined
// - Oversize hsize is treated as full word.
// - Misaligned low bits are forced to an aligned lane mask.
// - Upper address bits are ignored (wrap).
// - hresp is always 00.
// TESTING
// - Reset: hresetn=0 mid-write, no cen after release; all outputs at reset values.
// - Word write 0x0000_0004 <= 0xA5A5_5A5A, then read it: cen[0] low for one cycle, wen=0000, hrdata=0xA5A5_5A5A one cycle after read address.
// - Byte write 0xEF to addr 0x2 (hsize=0): wen=1011; readback word shows 0xEF in bits[23:16], other bytes unchanged.
// - Write bank0 immediately followed by read bank0: one hready_resp=0 cycle; then read bank1: no stall.
// - Back-to-back 4-beat INCR writes across bank boundary (NUM_BANKS=4): cen walks banks, zero waits.
// - With AHB_SRAM_ERR_RESP_EN, hsize=3: hresp=01 for 2 cycles, hready_resp 0 then 1, no cen.
// - Without AHB_SRAM_ERR_RESP_EN, hsize=3: treated as a word access, OKAY.

Source files
------------

// File: rtl/ahb_sram_bank_if.sv
// AHB-Lite slave front-end: decodes transfers into per-bank, per-lane SRAM strobes.
// Optional two-cycle ERROR response for illegal transfers under `define AHB_SRAM_ERR_RESP_EN.
module ahb_sram_bank_if #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int SRAM_ADDR_WIDTH = 13,
    parameter int NUM_BANKS       = 2
) (
    input  logic                            hclk,
    input  logic                            hresetn,
    input  logic                            hsel,
    input  logic [ADDR_WIDTH-1:0]           haddr,
    input  logic                            hwrite,
    input  logic [1:0]                      htrans,
    input  logic [2:0]                      hsize,
    input  logic [2:0]                      hburst,
    input  logic                            hready,
    input  logic [DATA_WIDTH-1:0]           hwdata,
    output logic                            hready_resp,
    output logic [1:0]                      hresp,
    output logic [DATA_WIDTH-1:0]           hrdata,
    output logic [NUM_BANKS-1:0]            sram_cen,
    output logic [DATA_WIDTH/8-1:0]         sram_wen,
    output logic [SRAM_ADDR_WIDTH-1:0]      sram_addr,
    output logic [DATA_WIDTH-1:0]           sram_wdata,
    input  logic [NUM_BANKS*DATA_WIDTH-1:0] sram_rdata
);

    localparam int LANES     = DATA_WIDTH / 8;
    localparam int LSB       = $clog2(LANES);
    localparam int OW        = (LSB > 0) ? LSB : 1;
    localparam int NW        = LSB + 2;
    localparam int MW        = 2 * LANES;
    localparam int BANK_BITS = $clog2(NUM_BANKS);
    localparam int BW        = (BANK_BITS > 0) ? BANK_BITS : 1;
    localparam int BANK_LSB  = LSB + SRAM_ADDR_WIDTH;
    localparam int HI_LSB    = BANK_LSB + BANK_BITS;

`ifdef AHB_SRAM_ERR_RESP_EN
    typedef enum logic [1:0] {S_IDLE, S_WR, S_ERR1, S_ERR2} state_t;
`else
    typedef enum logic [0:0] {S_IDLE, S_WR} state_t;
`endif

    state_t                     r_state;
    logic [SRAM_ADDR_WIDTH-1:0] r_wr_addr;
    logic [BW-1:0]              r_wr_bank;
    logic [LANES-1:0]           r_wr_mask;
    logic                       r_rd_phase;
    logic [BW-1:0]              r_rd_bank;

    logic                       w_valid;
    logic                       w_rd_req;
    logic                       w_collide;
    logic                       w_illegal;
    logic                       w_rd_issue;
    logic                       w_wr_issue;
    logic                       w_in_wr;
    logic [SRAM_ADDR_WIDTH-1:0] w_word;
    logic [BW-1:0]              w_bank;
    logic [OW-1:0]              w_off;
    logic [OW-1:0]              w_off_al;
    logic [2:0]                 w_size_eff;
    logic [NW-1:0]              w_nlanes;
    logic [MW-1:0]              w_span;
    logic [LANES-1:0]           w_mask;
    logic                       w_unused;

    assign w_unused = ^{hburst, haddr};

    assign w_valid    = hsel & hready & htrans[1];
    assign w_word     = haddr[LSB +: SRAM_ADDR_WIDTH];
    assign w_bank     = BW'((haddr >> BANK_LSB) & ADDR_WIDTH'(NUM_BANKS - 1));
    assign w_off      = (LSB > 0) ? haddr[OW-1:0] : '0;
    assign w_size_eff = (hsize > 3'(LSB)) ? 3'(LSB) : hsize;
    assign w_nlanes   = NW'(1) << w_size_eff;
    // Lane offset is rounded down to the transfer size so the mask never spills past the word.
    assign w_off_al   = w_off & ~OW'(w_nlanes - NW'(1));
    assign w_span     = (MW'(1) << w_nlanes) - MW'(1);
    assign w_mask     = LANES'(w_span << w_off_al);

`ifdef AHB_SRAM_ERR_RESP_EN
    assign w_illegal = (hsize > 3'(LSB))
                     || ((w_off & OW'(w_nlanes - NW'(1))) != '0)
                     || ((haddr >> HI_LSB) != '0);
`else
    assign w_illegal = 1'b0;
`endif

    assign w_in_wr = (r_state == S_WR);

    // Collision must not look at hready: hready is our own hready_resp fed back by the fabric.
    assign w_rd_req   = hsel & htrans[1] & ~hwrite;
    assign w_collide  = w_in_wr & w_rd_req & (w_bank == r_wr_bank);
    assign w_rd_issue = w_valid & ~hwrite & ~w_illegal & ~w_collide;
    assign w_wr_issue = w_valid & hwrite & ~w_illegal;

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_state    <= S_IDLE;
            r_wr_addr  <= '0;
            r_wr_bank  <= '0;
            r_wr_mask  <= '0;
            r_rd_phase <= 1'b0;
            r_rd_bank  <= '0;
        end else begin
            r_rd_phase <= w_rd_issue;
            if (w_rd_issue) begin
                r_rd_bank <= w_bank;
            end
            if (w_wr_issue) begin
                r_wr_addr <= w_word;
                r_wr_bank <= w_bank;
                r_wr_mask <= w_mask;
            end
`ifdef AHB_SRAM_ERR_RESP_EN
            if (r_state == S_ERR1)          r_state <= S_ERR2;
            else if (w_valid && w_illegal) r_state <= S_ERR1;
            else if (w_wr_issue)           r_state <= S_WR;
            else                           r_state <= S_IDLE;
`else
            r_state <= w_wr_issue ? S_WR : S_IDLE;
`endif
        end
    end

`ifdef AHB_SRAM_ERR_RESP_EN
    assign hready_resp = ~w_collide & (r_state != S_ERR1);
    assign hresp       = ((r_state == S_ERR1) || (r_state == S_ERR2)) ? 2'b01 : 2'b00;
`else
    assign hready_resp = ~w_collide;
    assign hresp       = 2'b00;
`endif

    always_comb begin
        sram_cen = '1;
        if (w_in_wr) begin
            sram_cen[r_wr_bank] = 1'b0;
        end
        if (w_rd_issue) begin
            sram_cen[w_bank] = 1'b0;
        end
    end

    // The address bus is shared: a parallel read to another bank sees the write's word index.
    assign sram_addr  = w_in_wr ? r_wr_addr : w_word;
    assign sram_wen   = w_in_wr ? ~r_wr_mask : '1;
    assign sram_wdata = w_in_wr ? hwdata : '0;
    assign hrdata     = r_rd_phase ? sram_rdata[int'(r_rd_bank) * DATA_WIDTH +: DATA_WIDTH] : '0;

endmodule

// File: tb/tb_ahb_sram_bank_if.sv
// Directed self-checking bench for ahb_sram_bank_if (4 banks) with a behavioural SRAM model.
// Covers both builds; the AHB_SRAM_ERR_RESP_EN macro selects the oversize-transfer expectations.
module tb_ahb_sram_bank_if;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SAW = 13;
    localparam int NB  = 4;

    logic            hclk;
    logic            hresetn;
    logic            hsel;
    logic [AW-1:0]   haddr;
    logic            hwrite;
    logic [1:0]      htrans;
    logic [2:0]      hsize;
    logic [2:0]      hburst;
    logic            hready;
    logic [DW-1:0]   hwdata;
    logic            hready_resp;
    logic [1:0]      hresp;
    logic [DW-1:0]   hrdata;
    logic [NB-1:0]   sram_cen;
    logic [3:0]      sram_wen;
    logic [SAW-1:0]  sram_addr;
    logic [DW-1:0]   sram_wdata;
    logic [NB*DW-1:0] sram_rdata;

    int n_pass;
    int n_total;

    logic [31:0] mem [NB][2**SAW];

    ahb_sram_bank_if #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SRAM_ADDR_WIDTH(SAW), .NUM_BANKS(NB)
    ) dut (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel), .haddr(haddr), .hwrite(hwrite),
        .htrans(htrans), .hsize(hsize), .hburst(hburst), .hready(hready), .hwdata(hwdata),
        .hready_resp(hready_resp), .hresp(hresp), .hrdata(hrdata), .sram_cen(sram_cen),
        .sram_wen(sram_wen), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata)
    );

    assign hready = hready_resp;

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    always @(posedge hclk) begin
        for (int b = 0; b < NB; b++) begin
            if (!sram_cen[b]) begin
                for (int l = 0; l < 4; l++) begin
                    if (!sram_wen[l]) mem[b][sram_addr][8*l +: 8] <= sram_wdata[8*l +: 8];
                end
                sram_rdata[b*DW +: DW] <= mem[b][sram_addr];
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge hclk);
        #1;
    endtask

    task automatic mid();
        @(negedge hclk);
    endtask

    task automatic bus_idle();
        hsel   = 1'b0;
        htrans = 2'b00;
        hwrite = 1'b0;
        haddr  = '0;
        hsize  = 3'd2;
    endtask

    task automatic addr_ph(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                           input logic [1:0] tr);
        hsel   = 1'b1;
        htrans = tr;
        hwrite = wr;
        haddr  = a;
        hsize  = sz;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        for (int b = 0; b < NB; b++)
            for (int w = 0; w < 2**SAW; w++) mem[b][w] = '0;
        sram_rdata = '0;
        hresetn = 1'b0;
        hburst  = 3'b000;
        hwdata  = '0;
        bus_idle();
        repeat (3) @(posedge hclk);
        #1;

        mid();
        chk("rst_hready", hready_resp, 1'b1);
        chk("rst_hresp", hresp, 2'b00);
        chk("rst_hrdata", hrdata, 32'h0);
        chk("rst_cen", sram_cen, 4'hF);
        chk("rst_wen", sram_wen, 4'hF);
        cyc();
        hresetn = 1'b1;

        // Reset in the middle of a write data phase
        cyc();
        addr_ph(1'b1, 32'h10, 3'd2, 2'b10);
        cyc();
        bus_idle();
        hwdata = 32'h5555_5555;
        #2 hresetn = 1'b0;
        mid();
        chk("midrst_cen", sram_cen, 4'hF);
        chk("midrst_wen", sram_wen, 4'hF);
        cyc();
        hresetn = 1'b1;
        mid();
        chk("midrst_cen_after", sram_cen, 4'hF);
        chk("midrst_hready", hready_resp, 1'b1);
        cyc();

        // Word write then read
        addr_ph(1'b1, 32'h4, 3'd2, 2'b10);
        mid();
        chk("ww_addr_cen", sram_cen, 4'hF);
        cyc();
        bus_idle();
        hwdata = 32'hA5A5_5A5A;
        mid();
        chk("ww_cen", sram_cen, 4'b1110);
        chk("ww_wen", sram_wen, 4'b0000);
        chk("ww_addr", sram_addr, 13'd1);
        chk("ww_wdata", sram_wdata, 32'hA5A5_5A5A);
        chk("ww_hready", hready_resp, 1'b1);
        cyc();
        mid();
        chk("ww_done_cen", sram_cen, 4'hF);
        cyc();
        addr_ph(1'b0, 32'h4, 3'd2, 2'b10);
        mid();
        chk("wr_rd_cen", sram_cen, 4'b1110);
        chk("wr_rd_wen", sram_wen, 4'hF);
        chk("wr_rd_addr", sram_addr, 13'd1);
        cyc();
        bus_idle();
        mid();
        chk("wr_rd_data", hrdata, 32'hA5A5_5A5A);
        chk("wr_rd_cen_off", sram_cen, 4'hF);
        cyc();
        mid();
        chk("hrdata_idle_zero", hrdata, 32'h0);
        cyc();

        // Byte write into lane 2
        addr_ph(1'b1, 32'h0, 3'd2, 2'b10);
        cyc();
        hwdata = 32'h1122_3344;
        addr_ph(1'b1, 32'h2, 3'd0, 2'b10);
        mid();
        chk("bw_word_wen", sram_wen, 4'b0000);
        chk("waw_hready", hready_resp, 1'b1);
        cyc();
        hwdata = 32'h00EF_0000;
        bus_idle();
        mid();
        chk("bw_wen", sram_wen, 4'b1011);
        chk("bw_cen", sram_cen, 4'b1110);
        cyc();
        addr_ph(1'b0, 32'h0, 3'd2, 2'b10);
        cyc();
        bus_idle();
        mid();
        chk("bw_readback", hrdata, 32'h11EF_3344);
        cyc();

        // Same-bank read after write stalls one cycle
        addr_ph(1'b1, 32'h8, 3'd2, 2'b10);
        cyc();
        hwdata = 32'hDEAD_BEEF;
        addr_ph(1'b0, 32'h8, 3'd2, 2'b10);
        mid();
        chk("coll_stall", hready_resp, 1'b0);
        chk("coll_wr_cen", sram_cen, 4'b1110);
        chk("coll_wr_wen", sram_wen, 4'b0000);
        cyc();
        mid();
        chk("coll_rd_hready", hready_resp, 1'b1);
        chk("coll_rd_cen", sram_cen, 4'b1110);
        chk("coll_rd_wen", sram_wen, 4'hF);
        chk("coll_rd_addr", sram_addr, 13'd2);
        cyc();
        addr_ph(1'b1, 32'h800C, 3'd2, 2'b10);
        mid();
        chk("coll_rd_data", hrdata, 32'hDEAD_BEEF);
        cyc();
        hwdata = 32'hCAFE_F00D;
        addr_ph(1'b1, 32'hC, 3'd2, 2'b10);
        mid();
        chk("b1_wr_cen", sram_cen, 4'b1101);
        cyc();
        hwdata = 32'h1234_5678;
        addr_ph(1'b0, 32'h800C, 3'd2, 2'b10);
        mid();
        chk("par_no_stall", hready_resp, 1'b1);
        chk("par_cen", sram_cen, 4'b1100);
        chk("par_addr", sram_addr, 13'd3);
        cyc();
        bus_idle();
        mid();
        chk("par_rd_data", hrdata, 32'hCAFE_F00D);
        chk("par_cen_off", sram_cen, 4'hF);
        cyc();

        // INCR4 burst crossing from bank 0 into bank 1
        hburst = 3'b011;
        addr_ph(1'b1, 32'h7FF8, 3'd2, 2'b10);
        cyc();
        hwdata = 32'h1000_0000;
        addr_ph(1'b1, 32'h7FFC, 3'd2, 2'b11);
        mid();
        chk("burst0_cen", sram_cen, 4'b1110);
        chk("burst0_addr", sram_addr, 13'h1FFE);
        chk("burst0_hready", hready_resp, 1'b1);
        cyc();
        hwdata = 32'h1000_0001;
        addr_ph(1'b1, 32'h8000, 3'd2, 2'b11);
        mid();
        chk("burst1_cen", sram_cen, 4'b1110);
        chk("burst1_addr", sram_addr, 13'h1FFF);
        cyc();
        hwdata = 32'h1000_0002;
        addr_ph(1'b1, 32'h8004, 3'd2, 2'b11);
        mid();
        chk("burst2_cen", sram_cen, 4'b1101);
        chk("burst2_addr", sram_addr, 13'h0);
        chk("burst2_hready", hready_resp, 1'b1);
        cyc();
        hwdata = 32'h1000_0003;
        bus_idle();
        mid();
        chk("burst3_cen", sram_cen, 4'b1101);
        chk("burst3_addr", sram_addr, 13'h1);
        cyc();
        hburst = 3'b000;
        addr_ph(1'b0, 32'h8000, 3'd2, 2'b10);
        mid();
        chk("burst_rd_cen", sram_cen, 4'b1101);
        cyc();
        bus_idle();
        mid();
        chk("burst_rd_data", hrdata, 32'h1000_0002);
        cyc();

        // Oversize transfer (hsize=3)
        addr_ph(1'b0, 32'h4, 3'd3, 2'b10);
`ifdef AHB_SRAM_ERR_RESP_EN
        mid();
        chk("err_addr_cen", sram_cen, 4'hF);
        chk("err_addr_hresp", hresp, 2'b00);
        cyc();
        bus_idle();
        mid();
        chk("err1_hresp", hresp, 2'b01);
        chk("err1_hready", hready_resp, 1'b0);
        chk("err1_cen", sram_cen, 4'hF);
        cyc();
        mid();
        chk("err2_hresp", hresp, 2'b01);
        chk("err2_hready", hready_resp, 1'b1);
        chk("err2_hrdata", hrdata, 32'h0);
        cyc();
        mid();
        chk("err_done_hresp", hresp, 2'b00);
`else
        mid();
        chk("big_cen", sram_cen, 4'b1110);
        chk("big_hresp", hresp, 2'b00);
        cyc();
        bus_idle();
        mid();
        chk("big_hready", hready_resp, 1'b1);
        chk("big_rd_data", hrdata, 32'hA5A5_5A5A);
        chk("big_hresp_data", hresp, 2'b00);
`endif
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
